// File: rtl/mc_controller_hs.sv
// Multicycle control FSM for the non-pipelined MIPS-style datapath, with req/ack
// memory handshakes, wait-state timeout, sticky trap and a retired-instruction counter.
module mc_controller_hs #(
  parameter int ALU_FUNC_W = 4,
  parameter int WAIT_MAX   = 15,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           Instr,
  input  logic                  Zero,
  input  logic                  IMEM_Ack,
  input  logic                  MEM_Ack,
  output logic                  IMEM_Req,
  output logic                  IR_LdEn,
  output logic                  PC_LdEn,
  output logic                  PC_sel,
  output logic                  RF_B_sel,
  output logic                  RF_WrEn,
  output logic                  RF_WrData_sel,
  output logic                  ALU_Bin_sel,
  output logic [1:0]            Imm_sel,
  output logic [ALU_FUNC_W-1:0] ALU_func,
  output logic                  MEM_Req,
  output logic                  MEM_WrEn,
  output logic                  MEM_ByteEn,
  output logic                  Trap,
  output logic [3:0]            State,
  output logic [CNT_W-1:0]      Retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_BRANCH    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_LD_WB     = 4'd7,
    S_ALU_EXEC  = 4'd8,
    S_ALU_WB    = 4'd9,
    S_TRAP      = 4'd14,
    S_PC_UPDATE = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  localparam logic [ALU_FUNC_W-1:0] FN_ADD = ALU_FUNC_W'(0);
  localparam logic [ALU_FUNC_W-1:0] FN_SUB = ALU_FUNC_W'(1);
  localparam logic [ALU_FUNC_W-1:0] FN_AND = ALU_FUNC_W'(2);
  localparam logic [ALU_FUNC_W-1:0] FN_OR  = ALU_FUNC_W'(3);

  // Counter is one bit wider than needed so WAIT_MAX itself is representable.
  localparam int WAIT_W = $clog2(WAIT_MAX + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t             state;
  logic               take_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retired;

  logic [5:0] opcode;
  logic [4:0] rd;
  logic       rd_zero;
  logic       is_rtype, is_li, is_lui, is_addi, is_andi, is_ori;
  logic       is_lw, is_lb, is_sw, is_sb, is_b, is_beq, is_bne;
  logic       is_alu, is_load, is_store, is_branch;
  logic       wait_expired;
  logic       unused_instr_bits;

  assign opcode   = Instr[31:26];
  assign rd       = Instr[20:16];
  assign rd_zero  = (rd == 5'd0);
  assign unused_instr_bits = ^{Instr[25:21], Instr[15:4]};

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_li    = (opcode == OP_LI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_andi  = (opcode == OP_ANDI);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lw    = (opcode == OP_LW);
  assign is_lb    = (opcode == OP_LB);
  assign is_sw    = (opcode == OP_SW);
  assign is_sb    = (opcode == OP_SB);
  assign is_b     = (opcode == OP_B);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);

  assign is_alu    = is_rtype | is_li | is_lui | is_addi | is_andi | is_ori;
  assign is_load   = is_lw | is_lb;
  assign is_store  = is_sw | is_sb;
  assign is_branch = is_b | is_beq | is_bne;

  assign wait_expired = (WAIT_MAX > 0) && (wait_cnt == WAIT_LAST);

  // wait_cnt defaults to clear, so it is zero on entry to every wait state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_FETCH;
      take_q   <= 1'b0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (IMEM_Ack)          state <= S_DECODE;
          else if (wait_expired) state <= S_TRAP;
          else                   wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: begin
          if (is_alu)                    state <= rd_zero ? S_PC_UPDATE : S_ALU_EXEC;
          else if (is_load || is_store)  state <= S_MEM_ADDR;
          else if (is_branch)            state <= S_BRANCH;
          else                           state <= S_TRAP;
        end
        S_ALU_EXEC: state <= S_ALU_WB;
        S_ALU_WB:   state <= S_PC_UPDATE;
        S_MEM_ADDR: state <= is_store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (MEM_Ack)           state <= rd_zero ? S_PC_UPDATE : S_LD_WB;
          else if (wait_expired) state <= S_TRAP;
          else                   wait_cnt <= wait_cnt + 1'b1;
        end
        S_MEM_WR: begin
          if (MEM_Ack)           state <= S_PC_UPDATE;
          else if (wait_expired) state <= S_TRAP;
          else                   wait_cnt <= wait_cnt + 1'b1;
        end
        S_LD_WB: state <= S_PC_UPDATE;
        S_BRANCH: begin
          take_q <= is_b | (is_beq & Zero) | (is_bne & ~Zero);
          state  <= S_PC_UPDATE;
        end
        S_PC_UPDATE: begin
          take_q  <= 1'b0;
          retired <= retired + 1'b1;
          state   <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Outputs decode from the state register; an active reset masks everything to zero.
  always_comb begin
    IMEM_Req      = 1'b0;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    Imm_sel       = 2'b00;
    ALU_func      = FN_ADD;
    MEM_Req       = 1'b0;
    MEM_WrEn      = 1'b0;
    MEM_ByteEn    = 1'b0;
    Trap          = 1'b0;
    State         = 4'd0;
    Retired       = '0;
    if (Reset) begin
      State   = state;
      Retired = retired;
      case (state)
        S_FETCH: begin
          IMEM_Req = 1'b1;
          IR_LdEn  = IMEM_Ack;
        end
        S_DECODE: RF_B_sel = is_sw | is_sb | is_beq | is_bne;
        S_ALU_EXEC, S_ALU_WB: begin
          if (is_rtype) begin
            ALU_func = ALU_FUNC_W'(Instr[3:0]);
          end else begin
            ALU_Bin_sel = 1'b1;
            if (is_andi) begin
              Imm_sel  = 2'b01;
              ALU_func = FN_AND;
            end else if (is_ori) begin
              Imm_sel  = 2'b01;
              ALU_func = FN_OR;
            end else if (is_lui) begin
              Imm_sel  = 2'b10;
            end
          end
          if (state == S_ALU_WB) RF_WrEn = 1'b1;
        end
        S_MEM_ADDR: ALU_Bin_sel = 1'b1;
        S_MEM_RD: begin
          ALU_Bin_sel = 1'b1;
          MEM_Req     = 1'b1;
          MEM_ByteEn  = is_lb;
        end
        S_MEM_WR: begin
          ALU_Bin_sel = 1'b1;
          RF_B_sel    = 1'b1;
          MEM_Req     = 1'b1;
          MEM_WrEn    = 1'b1;
          MEM_ByteEn  = is_sb;
        end
        S_LD_WB: begin
          RF_WrEn       = 1'b1;
          RF_WrData_sel = 1'b1;
        end
        S_BRANCH: begin
          RF_B_sel = 1'b1;
          ALU_func = FN_SUB;
        end
        S_PC_UPDATE: begin
          PC_LdEn = 1'b1;
          PC_sel  = take_q;
        end
        S_TRAP:  Trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Scoreboard bench for mc_controller_hs: the stimulus queues a hand-computed
// per-cycle expectation, and a negedge monitor pops and compares it.
module tb_mc_controller_hs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        zero, imem_ack, mem_ack;

  logic        imem_req, ir_ld_en, pc_ld_en, pc_sel, rf_b_sel, rf_wr_en, rf_wr_data_sel;
  logic        alu_bin_sel, mem_req, mem_wr_en, mem_byte_en, trap;
  logic [1:0]  imm_sel;
  logic [3:0]  alu_func, state, retired;
  logic [17:0] ctrl;

  localparam logic [17:0] IREQ  = 18'h00001, IRLD = 18'h00002, PCLD  = 18'h00004;
  localparam logic [17:0] PCSEL = 18'h00008, BSEL = 18'h00010, WREN  = 18'h00020;
  localparam logic [17:0] WDSEL = 18'h00040, BIN  = 18'h00080, IMMZ  = 18'h00100;
  localparam logic [17:0] IMMU  = 18'h00200, FSUB = 18'h00400, FOR   = 18'h00C00;
  localparam logic [17:0] MREQ  = 18'h04000, MWR  = 18'h08000, BYTE  = 18'h10000;
  localparam logic [17:0] TRAPB = 18'h20000, FET  = 18'h00003;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [3:0]  ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  mc_controller_hs #(.ALU_FUNC_W(4), .WAIT_MAX(4), .CNT_W(4)) dut (
    .Clk(clk), .Reset(reset_n), .Instr(instr), .Zero(zero),
    .IMEM_Ack(imem_ack), .MEM_Ack(mem_ack),
    .IMEM_Req(imem_req), .IR_LdEn(ir_ld_en), .PC_LdEn(pc_ld_en), .PC_sel(pc_sel),
    .RF_B_sel(rf_b_sel), .RF_WrEn(rf_wr_en), .RF_WrData_sel(rf_wr_data_sel),
    .ALU_Bin_sel(alu_bin_sel), .Imm_sel(imm_sel), .ALU_func(alu_func),
    .MEM_Req(mem_req), .MEM_WrEn(mem_wr_en), .MEM_ByteEn(mem_byte_en),
    .Trap(trap), .State(state), .Retired(retired)
  );

  assign ctrl = {trap, mem_byte_en, mem_wr_en, mem_req, alu_func, imm_sel, alu_bin_sel,
                 rf_wr_data_sel, rf_wr_en, rf_b_sel, pc_sel, pc_ld_en, ir_ld_en, imem_req};

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({state, ctrl, retired} === {e.st, e.ctl, e.ret}) passes++;
    else $display("[TB] FAIL %s: got state=%0d ctrl=%05h retired=%0d, expected state=%0d ctrl=%05h retired=%0d",
                  e.name, state, ctrl, retired, e.st, e.ctl, e.ret);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input string name, input logic iack, input logic mack, input logic z,
                               input logic [3:0] st, input logic [17:0] c, input logic [3:0] r);
    exp_t e;
    imem_ack = iack;
    mem_ack  = mack;
    zero     = z;
    e.name = name; e.st = st; e.ctl = c; e.ret = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Single-cycle FETCH/DECODE/PC_UPDATE no-op (rd==0 R-type).
  task automatic noop(input logic [3:0] r);
    instr = 32'h80400000;
    applyStimulus("nop_fetch",  1, 0, 0, 4'd0,  FET,  r);
    applyStimulus("nop_decode", 1, 0, 0, 4'd1,  '0,   r);
    applyStimulus("nop_pcupd",  1, 0, 0, 4'd15, PCLD, r);
  endtask

  task automatic branch(input logic [31:0] ins, input logic z, input logic [17:0] dec,
                        input logic [17:0] pcu, input logic [3:0] r);
    instr = ins;
    applyStimulus("br_fetch",  1, 0, 0, 4'd0,  FET,         r);
    applyStimulus("br_decode", 1, 0, 0, 4'd1,  dec,         r);
    applyStimulus("br_exec",   1, 0, z, 4'd2,  BSEL | FSUB, r);
    applyStimulus("br_pcupd",  1, 0, 0, 4'd15, pcu,         r);
  endtask

  initial begin
    reset_n = 1'b0; instr = 32'h0; zero = 0; imem_ack = 1; mem_ack = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 1, 0, 0, 4'd0, '0, 4'd0);
    reset_n = 1'b1;

    instr = 32'h80430000;
    applyStimulus("add_fetch",  1, 0, 0, 4'd0,  FET,  4'd0);
    applyStimulus("add_decode", 1, 0, 0, 4'd1,  '0,   4'd0);
    applyStimulus("add_exec",   1, 0, 0, 4'd8,  '0,   4'd0);
    applyStimulus("add_wb",     1, 0, 0, 4'd9,  WREN, 4'd0);
    applyStimulus("add_pcupd",  1, 0, 0, 4'd15, PCLD, 4'd0);
    noop(4'd1);

    instr = 32'h80430003;
    applyStimulus("or_fetch_wait", 0, 0, 0, 4'd0, IREQ, 4'd2);
    applyStimulus("or_fetch_wait", 0, 0, 0, 4'd0, IREQ, 4'd2);
    applyStimulus("or_fetch",      1, 0, 0, 4'd0, FET,  4'd2);
    applyStimulus("or_decode",     1, 0, 0, 4'd1, '0,   4'd2);
    applyStimulus("or_exec",       1, 0, 0, 4'd8, FOR,  4'd2);
    applyStimulus("or_wb",         1, 0, 0, 4'd9, FOR | WREN, 4'd2);
    applyStimulus("or_pcupd",      1, 0, 0, 4'd15, PCLD, 4'd2);

    instr = 32'hCC020000;
    applyStimulus("ori_fetch",  1, 0, 0, 4'd0,  FET, 4'd3);
    applyStimulus("ori_decode", 1, 0, 0, 4'd1,  '0,  4'd3);
    applyStimulus("ori_exec",   1, 0, 0, 4'd8,  BIN | IMMZ | FOR, 4'd3);
    applyStimulus("ori_wb",     1, 0, 0, 4'd9,  BIN | IMMZ | FOR | WREN, 4'd3);
    applyStimulus("ori_pcupd",  1, 0, 0, 4'd15, PCLD, 4'd3);

    instr = 32'hE4020000;
    applyStimulus("lui_fetch",  1, 0, 0, 4'd0,  FET, 4'd4);
    applyStimulus("lui_decode", 1, 0, 0, 4'd1,  '0,  4'd4);
    applyStimulus("lui_exec",   1, 0, 0, 4'd8,  BIN | IMMU, 4'd4);
    applyStimulus("lui_wb",     1, 0, 0, 4'd9,  BIN | IMMU | WREN, 4'd4);
    applyStimulus("lui_pcupd",  1, 0, 0, 4'd15, PCLD, 4'd4);

    // LW with three wait states; ack arrives on the last permitted cycle.
    instr = 32'h3C050000;
    applyStimulus("lw_fetch",   1, 0, 0, 4'd0, FET, 4'd5);
    applyStimulus("lw_decode",  1, 0, 0, 4'd1, '0,  4'd5);
    applyStimulus("lw_addr",    1, 0, 0, 4'd3, BIN, 4'd5);
    for (int i = 0; i < 3; i++) applyStimulus("lw_rd_wait", 1, 0, 0, 4'd4, MREQ | BIN, 4'd5);
    applyStimulus("lw_rd_ack",  1, 1, 0, 4'd4, MREQ | BIN, 4'd5);
    applyStimulus("lw_wb",      1, 0, 0, 4'd7, WREN | WDSEL, 4'd5);
    applyStimulus("lw_pcupd",   1, 0, 0, 4'd15, PCLD, 4'd5);

    instr = 32'h0C050000;
    applyStimulus("lb_fetch",   1, 0, 0, 4'd0, FET, 4'd6);
    applyStimulus("lb_decode",  1, 0, 0, 4'd1, '0,  4'd6);
    applyStimulus("lb_addr",    1, 0, 0, 4'd3, BIN, 4'd6);
    applyStimulus("lb_rd",      1, 1, 0, 4'd4, MREQ | BIN | BYTE, 4'd6);
    applyStimulus("lb_wb",      1, 0, 0, 4'd7, WREN | WDSEL, 4'd6);
    applyStimulus("lb_pcupd",   1, 0, 0, 4'd15, PCLD, 4'd6);

    instr = 32'h1C000000;
    applyStimulus("sb_fetch",   1, 0, 0, 4'd0, FET,  4'd7);
    applyStimulus("sb_decode",  1, 0, 0, 4'd1, BSEL, 4'd7);
    applyStimulus("sb_addr",    1, 0, 0, 4'd3, BIN,  4'd7);
    applyStimulus("sb_wr",      1, 1, 0, 4'd5, MREQ | MWR | BYTE | BSEL | BIN, 4'd7);
    applyStimulus("sb_pcupd",   1, 0, 0, 4'd15, PCLD, 4'd7);

    branch(32'h00000000, 1'b1, BSEL, PCLD | PCSEL, 4'd8);
    branch(32'h04000000, 1'b1, BSEL, PCLD,         4'd9);
    branch(32'hFC000000, 1'b1, '0,   PCLD | PCSEL, 4'd10);
    branch(32'h00000000, 1'b0, BSEL, PCLD,         4'd11);
    branch(32'h04000000, 1'b0, BSEL, PCLD | PCSEL, 4'd12);

    noop(4'd13);
    noop(4'd14);
    noop(4'd15);
    noop(4'd0);

    // Reset asserted while a store is waiting for its ack.
    instr = 32'h7C000000;
    applyStimulus("sw_fetch",   1, 0, 0, 4'd0, FET,  4'd1);
    applyStimulus("sw_decode",  1, 0, 0, 4'd1, BSEL, 4'd1);
    applyStimulus("sw_addr",    1, 0, 0, 4'd3, BIN,  4'd1);
    applyStimulus("sw_wr_wait", 1, 0, 0, 4'd5, MREQ | MWR | BSEL | BIN, 4'd1);
    reset_n = 1'b0;
    applyStimulus("mid_reset",  1, 0, 0, 4'd0, '0, 4'd0);
    reset_n = 1'b1;
    applyStimulus("post_reset_fetch", 0, 0, 0, 4'd0, IREQ, 4'd0);
    noop(4'd0);

    // Store whose ack never comes: four request cycles, then sticky trap.
    instr = 32'h7C000000;
    applyStimulus("swto_fetch",  1, 0, 0, 4'd0, FET,  4'd1);
    applyStimulus("swto_decode", 1, 0, 0, 4'd1, BSEL, 4'd1);
    applyStimulus("swto_addr",   1, 0, 0, 4'd3, BIN,  4'd1);
    for (int i = 0; i < 4; i++) applyStimulus("swto_wr_wait", 1, 0, 0, 4'd5, MREQ | MWR | BSEL | BIN, 4'd1);
    for (int i = 0; i < 5; i++) applyStimulus("swto_trap", 1, 1, 0, 4'd14, TRAPB, 4'd1);

    reset_n = 1'b0;
    applyStimulus("trap_reset", 1, 0, 0, 4'd0, '0, 4'd0);
    reset_n = 1'b1;

    instr = 32'hA8000000;
    applyStimulus("ill_fetch",  1, 0, 0, 4'd0, FET, 4'd0);
    applyStimulus("ill_decode", 1, 0, 0, 4'd1, '0,  4'd0);
    for (int i = 0; i < 20; i++) applyStimulus("ill_trap", 1, 1, 0, 4'd14, TRAPB, 4'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller_hs.md
Name: mc_controller_hs

Overview:
Parametrised multicycle control FSM for the non-pipelined MIPS-style datapath. It succeeds the fixed single-cycle-memory controller and adds req/ack handshakes with wait states for instruction and data memory, a programmable timeout, byte-access control, immediate-extension select, a registered branch decision, a sticky trap on illegal opcode or timeout, and a retired-instruction counter. Outputs are decoded from the state register, except the branch decision, which is sampled from Zero.

Parameters:
ALU_FUNC_W, 4, ALU_func width; function codes ADD=0, SUB=1, AND=2, OR=3 (zero-extended to this width).
WAIT_MAX, 15, max consecutive un-acked request cycles before trap; 0 disables timeout.
CNT_W, 16, width of Retired counter.

Ports:
Clk  in  1  clock, all state updates on posedge.
Reset  in  1  synchronous, active-low; Reset==0 at a posedge resets the block.
Instr  in  32  instruction register contents; opcode Instr[31:26], rd Instr[20:16], R-type function Instr[3:0].
Zero  in  1  ALU zero flag.
IMEM_Ack  in  1  instruction memory ack.
MEM_Ack  in  1  data memory ack.
IMEM_Req  out  1  instruction fetch request.
IR_LdEn  out  1  load instruction register.
PC_LdEn  out  1  load PC.
PC_sel  out  1  0=PC+4, 1=PC+4+(Imm<<2).
RF_B_sel  out  1  0=B reads rt, 1=B reads rd field.
RF_WrEn  out  1  register file write.
RF_WrData_sel  out  1  0=ALU_out, 1=MEM data.
ALU_Bin_sel  out  1  0=B, 1=immediate.
Imm_sel  out  2  00=sign-ext, 01=zero-ext, 10=imm<<16.
ALU_func  out  ALU_FUNC_W  ALU operation.
MEM_Req  out  1  data memory request.
MEM_WrEn  out  1  data memory write.
MEM_ByteEn  out  1  1=byte access (LB/SB).
Trap  out  1  sticky fault indicator.
State  out  4  current state code (debug).
Retired  out  CNT_W  completed-instruction count.

Behaviour:
- Opcodes: R_TYPE=100000; LI=111000, LUI=111001, ADDI=110000, ANDI=110010, ORI=110011; LW=001111, LB=000011, SW=011111, SB=000111; B=111111, BEQ=000000, BNE=000001. Any other opcode is illegal.
- State codes: FETCH=0, DECODE=1, BRANCH=2, MEM_ADDR=3, MEM_RD=4, MEM_WR=5, LD_WB=7, ALU_EXEC=8, ALU_WB=9, TRAP=14, PC_UPDATE=15.
- Default values: every output not listed for a state is 0; ALU_func defaults to ADD.
- Reset (Reset==0 at posedge): state=FETCH, take_q=0, wait_cnt=0, Retired=0. While Reset==0, all outputs are forced to 0 combinationally, State included.
- FETCH: IMEM_Req=1. When IMEM_Ack=1, IR_LdEn=1 in that cycle and next state is DECODE; otherwise stay in FETCH.
- DECODE: RF_B_sel=1 for SW, SB, BEQ, BNE. Next state:
  - R_TYPE, LI, LUI, ADDI, ANDI, ORI: rd==0 -> PC_UPDATE (no-op, still retired); else ALU_EXEC.
  - LW, LB, SW, SB -> MEM_ADDR.
  - B, BEQ, BNE -> BRANCH.
  - Illegal opcode -> TRAP.
- ALU_EXEC, then ALU_WB: both states drive the same ALU controls.
  - R_TYPE: Bin_sel=0, func=Instr[3:0].
  - ADDI, LI: Bin_sel=1, Imm_sel=00, func=ADD.
  - ANDI: Bin_sel=1, Imm_sel=01, func=AND.
  - ORI: Bin_sel=1, Imm_sel=01, func=OR.
  - LUI: Bin_sel=1, Imm_sel=10, func=ADD.
  - ALU_WB additionally drives RF_WrEn=1, RF_WrData_sel=0, and goes to PC_UPDATE.
- MEM_ADDR: Bin_sel=1, Imm_sel=00, func=ADD. Loads go to MEM_RD; stores go to MEM_WR.
- MEM_RD: MEM_Req=1, MEM_ByteEn=(LB), address controls held as in MEM_ADDR. On MEM_Ack: rd==0 -> PC_UPDATE, else LD_WB.
- MEM_WR: MEM_Req=1, MEM_WrEn=1, MEM_ByteEn=(SB), RF_B_sel=1, address controls held. On MEM_Ack -> PC_UPDATE.
- LD_WB: RF_WrEn=1, RF_WrData_sel=1, then PC_UPDATE.
- BRANCH: Bin_sel=0, RF_B_sel=1, func=SUB. take_q is registered as 1 for B, Zero for BEQ, !Zero for BNE. Next state is PC_UPDATE.
- PC_UPDATE: PC_LdEn=1, PC_sel=take_q. take_q clears and Retired increments (wraps modulo 2^CNT_W). Next state is FETCH.
- Wait/timeout (FETCH, MEM_RD, MEM_WR):
  - wait_cnt clears on entry to each wait state and increments each un-acked cycle.
  - If WAIT_MAX>0 and a cycle with wait_cnt==WAIT_MAX-1 also has no ack, next state is TRAP.
  - An ack in that same cycle wins.
  - Ack in the first request cycle means zero wait states.
- TRAP: Trap=1, all other outputs 0, State=14. The FSM stays here until reset; Retired is frozen.
- Latency with zero-wait memories:
  - ALU instruction: 5 cycles.
  - Branch: 4 cycles.
  - Load: 6 cycles.
  - Store: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset held low 3 cycles, then released, IMEM_Ack=1 -> all outputs 0 during reset; first cycle after release IMEM_Req=1, IR_LdEn=1, State=0.
- R-type ADD (Instr=0x80430000|func 0000, rd=3), acks immediate -> states 0,1,8,9,15; RF_WrEn=1 only in state 9; Retired=1 after 5 cycles. Same instruction with rd=0 -> 0,1,15, no RF_WrEn, Retired still increments.
- LW rd=5 with MEM_Ack delayed 3 cycles -> MEM_Req high 4 cycles, then LD_WB with RF_WrEn=1, RF_WrData_sel=1; total 9 cycles. LB -> MEM_ByteEn=1 during MEM_RD.
- Branches, with Zero=1 in BRANCH -> BEQ gives PC_sel=1 in PC_UPDATE, BNE gives PC_sel=0, B gives PC_sel=1. With Zero=0 the BEQ and BNE results invert.
- Illegal opcode 101010 -> TRAP after DECODE, Trap=1 held 20 cycles. Separately, WAIT_MAX=4 with MEM_Ack never asserted in MEM_WR -> TRAP after exactly 4 request cycles. Ack on the 4th cycle -> PC_UPDATE, no trap.
- Reset low mid-MEM_WR -> next cycle State=0, MEM_WrEn=0, Retired=0. With CNT_W=4, 16 retired no-ops -> Retired wraps to 0.
